dot_product_stream: RTL and testbench
=====================================

Name: dot_product_stream

Overview:
- Sequential streaming counterpart of the combinational `dot_product` engine.
- Accepts one (a[i], b[i]) element pair per beat over a valid/ready stream.
- Accumulates N products and presents the 32-bit dot product on a valid/ready result port.
- Sits between a vector source (DMA or loader) and the result consumer. It replaces the wide packed-vector interface (32*N bits per operand) with a 32-bit-per-operand serial interface.

Parameters:
- N, 8: number of element pairs per dot product; N >= 1.
- W, 32: element and result width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  element pair on in_a/in_b is valid.
- in_ready  out  1  block can accept an element pair this cycle.
- in_a  in  W  element a[i], unsigned.
- in_b  in  W  element b[i], unsigned.
- out_valid  out  1  out_result holds a completed dot product.
- out_ready  in  1  consumer accepts out_result this cycle.
- out_result  out  W  dot product, sum of a[i]*b[i] modulo 2^W.
- busy  out  1  high from first accepted beat until result handshake completes.
- elem_count  out  $clog2(N+1)  number of beats accepted in the current vector.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, accumulator=0, elem_count=0;
  - out_valid=0, out_result=0, busy=0;
  - in_ready=1 once rst_n deasserts.
- A beat is accepted when in_valid && in_ready on a rising clk edge.
- States:
  - IDLE: in_ready=1, busy=0. An accepted beat sets acc = in_a*in_b (truncated to W) and elem_count=1, then goes to ACCUM. If N==1, it goes straight to DONE.
  - ACCUM: in_ready=1, busy=1. An accepted beat sets acc = acc + in_a*in_b (mod 2^W) and increments elem_count. When the beat accepted is the N-th, go to DONE. With no beat, hold all state; gaps in in_valid are legal.
  - DONE: in_ready=0, out_valid=1, busy=1. out_result=acc, stable while out_ready=0. On out_valid && out_ready: go to IDLE, clear acc and elem_count, set out_valid=0.
- Latency: out_valid rises the cycle after the N-th beat is accepted. Minimum N+1 cycles per vector at full rate.
- Back-to-back vectors:
  - The first beat of the next vector is accepted no earlier than the cycle after the result handshake.
  - A result handshake and a new input beat never occur in the same cycle, because in_ready=0 in DONE.
- Arithmetic:
  - Unsigned W x W multiply; keep the low W bits of the product.
  - W-bit wrap-around add.
  - No overflow or saturation flag. The result is bit-exact with the combinational `dot_product` for the same vectors.
- in_a and in_b are ignored when in_valid=0 or in_ready=0. out_result is held at its last value (0 after reset) while out_valid=0.
- Reset mid-vector or mid-DONE:
  - Partial accumulation is discarded; the pending result is lost.
  - The next accepted beat starts a fresh vector.
- in_valid held high in DONE: no beat consumed. The upstream source must hold its data per valid/ready rules.

Decomposition:
- Shared package dot_product_pkg:
  - default W constant;
  - state enum (IDLE, ACCUM, DONE);
  - helper function for count width, clog2(N+1).
- One natural sub-module, mac_unit: combinational, acc_out = acc_in + low W bits of (a*b), mod 2^W, parameterised on W.
- The FSM, counter and handshake logic stay in dot_product_stream.

Test Plan:
- Basic: N=8, a[i]=i+1, b[i]=2*(i+1), in_valid continuous, out_ready=1. Expect:
  - out_valid high the cycle after the 8th beat;
  - out_result=408;
  - busy drops the cycle after the handshake.
- Backpressure and gaps:
  - Same vectors with in_valid deasserted for 2 cycles between beats 3 and 4. Expect elem_count held at 3 during the gap.
  - out_ready=0 for 5 cycles after completion. Expect out_valid=1, out_result=408 stable, in_ready=0 throughout; result consumed on the first out_ready=1.
- Wrap-around: a[i]=b[i]=0xFFFFFFFF for all 8 beats. Each product truncates to 1, so expect out_result=8.
- Back-to-back: vector 1 (all a=1, b=1), then vector 2 (a[i]=i, b[i]=3). Expect results 8, then 84. Vector 2's first beat is accepted exactly one cycle after the vector-1 handshake when in_valid is held high.
- Reset mid-operation:
  - Accept 3 beats of the basic vector, pulse rst_n low asynchronously between clock edges. Expect immediate elem_count=0, busy=0, out_valid=0.
  - Replay the full basic vector. Expect out_result=408.
- N=1 build: single beat a=7, b=6. Expect out_valid the next cycle with out_result=42 and no ACCUM cycle.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared types and constants for the streaming dot-product engine.
// Provides the default element width, the FSM state encoding and the count-width helper.
package dot_product_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bits needed to hold a beat count from 0 to n inclusive.
    function automatic int count_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dot_product_stream_mac_unit.sv
// Combinational multiply-accumulate: acc_out = acc_in + low W bits of (a*b), modulo 2^W.
module mac_unit #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_out
);

    logic [W-1:0] prod_s;

    // Product is truncated to W bits before the wrap-around add.
    always_comb begin
        prod_s  = a * b;
        acc_out = acc_in + prod_s;
    end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot product: one (a,b) pair per accepted beat, N beats per result,
// result offered on a valid/ready port and held until the consumer takes it.
module dot_product_stream
    import dot_product_pkg::*;
#(
    parameter int N = 8,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_result,
    output logic                 busy,
    output logic [count_w(N)-1:0] elem_count
);

    localparam int            CW   = count_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_result_q, out_result_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;

    logic          accept_s;
    logic          last_beat_s;
    logic [W-1:0]  mac_base_s;
    logic [W-1:0]  mac_sum_s;

    // The first beat of a vector starts from zero regardless of what acc holds.
    always_comb begin
        accept_s    = in_valid && in_ready_q;
        last_beat_s = (cnt_q == LAST);
        mac_base_s  = (state_q == ST_IDLE) ? {W{1'b0}} : acc_q;
    end

    mac_unit #(.W(W)) u_mac (
        .acc_in  (mac_base_s),
        .a       (in_a),
        .b       (in_b),
        .acc_out (mac_sum_s)
    );

    // Next-state and next-output logic for the IDLE/ACCUM/DONE controller.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        busy_d       = busy_q;
        in_ready_d   = in_ready_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    acc_d  = mac_sum_s;
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    busy_d = 1'b1;
                    // cnt_q is zero in IDLE, so N==1 finishes on the very first beat.
                    if (last_beat_s) begin
                        state_d      = ST_DONE;
                        in_ready_d   = 1'b0;
                        out_valid_d  = 1'b1;
                        out_result_d = mac_sum_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    acc_d       = {W{1'b0}};
                    cnt_d       = {CW{1'b0}};
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_d       = {W{1'b0}};
                cnt_d       = {CW{1'b0}};
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= {W{1'b0}};
            cnt_q        <= {CW{1'b0}};
            out_valid_q  <= 1'b0;
            out_result_q <= {W{1'b0}};
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign busy       = busy_q;
    assign elem_count = cnt_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream: scoreboard of expected results,
// one task per scenario, plus a second instance built with N=1.
module tb_dot_product_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;
    logic [3:0]  elem_count;

    logic        s1_in_valid = 1'b0;
    logic        s1_in_ready;
    logic [31:0] s1_in_a = 32'd0;
    logic [31:0] s1_in_b = 32'd0;
    logic        s1_out_valid;
    logic        s1_out_ready = 1'b1;
    logic [31:0] s1_out_result;
    logic        s1_busy;
    logic [0:0]  s1_elem_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dot_product_stream #(.N(8), .W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy), .elem_count(elem_count)
    );

    dot_product_stream #(.N(1), .W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_a(s1_in_a), .in_b(s1_in_b), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .out_result(s1_out_result), .busy(s1_busy), .elem_count(s1_elem_count)
    );

    // Present one beat from a negedge and return at the negedge after it is accepted.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, output int waits);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_beat_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_expected(input logic [31:0] a[8], input logic [31:0] b[8]);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 8; i++) sum = sum + a[i] * b[i];
        exp_q.push_back(sum);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            elem_count !== 4'd0 || out_result !== 32'd0) begin
            failures++;
            $display("FAIL reset_state rdy=%b vld=%b busy=%b cnt=%0d res=%0d required 1 0 0 0 0",
                     in_ready, out_valid, busy, elem_count, out_result);
        end
    endtask

    task automatic test_basic();
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic [31:0] exp;
        int w;
        for (int i = 0; i < 8; i++) begin a[i] = 32'(i + 1); b[i] = 32'(2 * (i + 1)); end
        push_expected(a, b);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(a[i], b[i], w);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1 || elem_count !== 4'd1) begin
                    failures++;
                    $display("FAIL basic_first_beat busy=%b cnt=%0d required busy=1 cnt=1", busy, elem_count);
                end
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || exp !== 32'd408) begin
            failures++;
            $display("FAIL basic_result vld=%b res=%0d required vld=1 res=%0d", out_valid, out_result, exp);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || elem_count !== 4'd8) begin
            failures++;
            $display("FAIL basic_done_flags busy=%b rdy=%b cnt=%0d required 1 0 8", busy, in_ready, elem_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || elem_count !== 4'd0) begin
            failures++;
            $display("FAIL basic_after_handshake vld=%b busy=%b rdy=%b cnt=%0d required 0 0 1 0",
                     out_valid, busy, in_ready, elem_count);
        end
    endtask

    task automatic test_backpressure_gaps();
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic [31:0] exp;
        int w;
        int t;
        for (int i = 0; i < 8; i++) begin a[i] = 32'(i + 1); b[i] = 32'(2 * (i + 1)); end
        push_expected(a, b);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_beat(a[i], b[i], w);
            if (i == 2) begin
                for (int g = 0; g < 2; g++) begin
                    in_a = 32'hDEAD_BEEF;
                    @(negedge clk);
                    checks++;
                    if (elem_count !== 4'd3) begin
                        failures++;
                        $display("FAIL gap_count_hold cnt=%0d required 3", elem_count);
                    end
                end
            end
        end
        exp = exp_q.pop_front();
        in_valid = 1'b1;
        in_a = 32'd1000;
        in_b = 32'd1000;
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0 || elem_count !== 4'd8) begin
                failures++;
                $display("FAIL stall_hold vld=%b res=%0d rdy=%b cnt=%0d required 1 %0d 0 8",
                         out_valid, out_result, in_ready, elem_count, exp);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (out_valid === 1'b1 && t < 3) begin @(negedge clk); t++; end
        checks++;
        if (t != 1 || out_valid !== 1'b0 || out_result !== exp) begin
            failures++;
            $display("FAIL stall_release cycles=%0d vld=%b res=%0d required 1 0 %0d", t, out_valid, out_result, exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic [31:0] exp;
        int w;
        for (int i = 0; i < 8; i++) begin a[i] = 32'hFFFF_FFFF; b[i] = 32'hFFFF_FFFF; end
        push_expected(a, b);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(a[i], b[i], w);
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || exp !== 32'd8) begin
            failures++;
            $display("FAIL wrap_result vld=%b res=%0d required vld=1 res=%0d", out_valid, out_result, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1[8];
        logic [31:0] b1[8];
        logic [31:0] a2[8];
        logic [31:0] b2[8];
        logic [31:0] exp;
        int w;
        for (int i = 0; i < 8; i++) begin
            a1[i] = 32'd1; b1[i] = 32'd1; a2[i] = 32'(i); b2[i] = 32'd3;
        end
        push_expected(a1, b1);
        push_expected(a2, b2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(a1[i], b1[i], w);
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || exp !== 32'd8) begin
            failures++;
            $display("FAIL b2b_vec1 vld=%b res=%0d required vld=1 res=%0d", out_valid, out_result, exp);
        end
        for (int i = 0; i < 8; i++) begin
            send_beat(a2[i], b2[i], w);
            if (i == 0) begin
                checks++;
                if (w != 1) begin
                    failures++;
                    $display("FAIL b2b_first_accept wait_cycles=%0d required 1", w);
                end
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || exp !== 32'd84) begin
            failures++;
            $display("FAIL b2b_vec2 vld=%b res=%0d required vld=1 res=%0d", out_valid, out_result, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic [31:0] exp;
        int w;
        for (int i = 0; i < 8; i++) begin a[i] = 32'(i + 1); b[i] = 32'(2 * (i + 1)); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(a[i], b[i], w);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (elem_count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid cnt=%0d busy=%b vld=%b required 0 0 0", elem_count, busy, out_valid);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        push_expected(a, b);
        for (int i = 0; i < 8; i++) send_beat(a[i], b[i], w);
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || exp !== 32'd408) begin
            failures++;
            $display("FAIL reset_replay vld=%b res=%0d required vld=1 res=%0d", out_valid, out_result, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_n1();
        logic [31:0] exp;
        exp_q.push_back(32'd7 * 32'd6);
        s1_out_ready = 1'b1;
        s1_in_valid = 1'b1;
        s1_in_a = 32'd7;
        s1_in_b = 32'd6;
        checks++;
        if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL n1_idle rdy=%b vld=%b required 1 0", s1_in_ready, s1_out_valid);
        end
        @(negedge clk);
        s1_in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (s1_out_valid !== 1'b1 || s1_out_result !== exp || exp !== 32'd42 ||
            s1_elem_count !== 1'b1 || s1_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL n1_result vld=%b res=%0d cnt=%0d rdy=%b required 1 %0d 1 0",
                     s1_out_valid, s1_out_result, s1_elem_count, s1_in_ready, exp);
        end
        @(negedge clk);
        checks++;
        if (s1_out_valid !== 1'b0 || s1_busy !== 1'b0 || s1_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL n1_handshake vld=%b busy=%b rdy=%b required 0 0 1", s1_out_valid, s1_busy, s1_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure_gaps();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_n1();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
